video_collision: RTL and testbench
==================================

# video_collision

Per-frame sprite collision detector for the 320x240 tile/sprite video peripheral. It sits directly downstream of the video pixel path and samples the per-pixel sprite-opaque and background-opaque signals that drive `vga_r/g/b`. It accumulates sprite-vs-sprite and sprite-vs-background hits over each visible frame and snapshots them at vsync. It exposes the results to the CPU over the iomem bus in the video window and can raise an IRQ.

## Interface
Parameters:
- `NUM_SPRITES`, default 8: number of hardware sprites, range 2..8.
- `VSYNC_ACTIVE_LOW`, default 1: polarity of `vga_vsync`.

Ports (one clock, `clk`; reset is `resetn`, asynchronous, active-low):
- `clk` in 1: pixel/system clock.
- `resetn` in 1: asynchronous active-low reset.
- `iomem_valid` in 1: bus request, already qualified by the SoC for 0x05xx_xxxx.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` is high.
- `video_active` in 1: current pixel is visible.
- `sprite_opaque` in `NUM_SPRITES`: bit i set when sprite i's pixel at this position is set.
- `bg_opaque` in 1: background texel is nonzero (any of RGB).
- `vga_vsync` in 1: vertical sync from the sync generator.
- `irq` out 1: level interrupt.

## Operation
- Block selected when `iomem_addr[23:20]==4'h4`. Register is `iomem_addr[4:2]`.
- Register map:
  - 0x00 CTRL (RW): bit0 ENABLE, bit1 IRQ_EN, bits[15:8] SS_MASK. Reset value 0.
  - 0x04 SS_HIT (RO): bit i = sprite i overlapped any other sprite last frame.
  - 0x08 BG_HIT (RO): bit i = sprite i overlapped opaque background last frame.
  - 0x0C FRAME (RO): 16-bit count of completed frames; wraps 0xFFFF->0.
  - 0x10 IRQ_STAT (W1C): bit0 pending.
  - Other offsets read 0; writes to them are ignored.
- Input stage registers `video_active`, `sprite_opaque`, `bg_opaque` and `vga_vsync` once. All detection uses the registered copies.
- Accumulate only when ENABLE=1 and the registered `video_active` is high:
  - `ss_work[i] |= opq[i] && |(opq & ~(1<<i))`.
  - `bg_work[i] |= opq[i] && bg`.
- Frame end is the vsync assertion edge, according to `VSYNC_ACTIVE_LOW`. On that edge:
  - SS_HIT <= `ss_work`; BG_HIT <= `bg_work`.
  - Both work registers clear to 0.
  - FRAME increments, regardless of ENABLE.
  - pending <= 1 if IRQ_EN and `|(ss_work & SS_MASK) || |bg_work`.
- `irq` = pending & IRQ_EN.
- Clearing ENABLE does not clear the work registers; they hold until the next frame edge.
- Simultaneous events:
  - Snapshot in the same cycle as an accumulating pixel: the pixel goes into the cleared work set.
  - W1C to IRQ_STAT in the same cycle as a set condition: set wins.
- Reset, including mid-frame: all registers, outputs, work sets and the edge-detect history go to 0. `irq`, `iomem_ready` and `iomem_rdata` are 0. The first vsync edge after reset is detected normally.

## Timing
- Pixel to work register: 2 cycles (input register, then accumulate).
- Vsync edge to SS_HIT/BG_HIT visible: 3 cycles (input register, edge detect, snapshot).
- Bus handshake:
  - `iomem_ready` rises 1 cycle after `iomem_valid` with select, and is high for exactly 1 cycle.
  - A write takes effect on the ready cycle.
  - `iomem_valid` held high past ready does not generate a second ready until it drops for at least 1 cycle.
- `irq` is a registered output, one cycle after pending sets.

## Configuration
- `VIDEO_COLLISION_BG_EN` defined: sprite-vs-background detection is built; `bg_opaque` is used, and BG_HIT feeds the IRQ condition.
- Undefined: `bg_work` and BG_HIT logic are removed; BG_HIT reads 0; the IRQ condition uses SS_HIT only; the `bg_opaque` port remains and is ignored.

## Structure
- Shared video package holds the register offset constants (`VC_CTRL`, `VC_SS_HIT`, `VC_BG_HIT`, `VC_FRAME`, `VC_IRQ_STAT`), the block-select value 4'h4, and the CTRL bit positions.
- One natural sub-module: `video_collision_regs`, for bus decode, the ready pulse, and CTRL/IRQ_STAT storage. Detection and snapshot stay in the top.

## Test plan
- Reset mid-frame after hits: assert `resetn`=0 for 1 cycle → all reads return 0, `irq`=0; next frame counts FRAME from 1.
- Sprites 0 and 3 opaque together on 1 active pixel, ENABLE=1 → after vsync, SS_HIT=0x09, BG_HIT=0, FRAME incremented by 1.
- Sprite 2 with `bg_opaque` on 1 pixel, IRQ_EN=1 → BG_HIT=0x04 and `irq`=1. A W1C write of 0x1 → `irq`=0. Without `VIDEO_COLLISION_BG_EN` → BG_HIT=0 and no irq.
- SS_MASK=0x01, collision of sprites 1 and 2 only → SS_HIT=0x06, no irq. Collision of sprites 0 and 1 → irq.
- Overlap pixels with `video_active`=0, or with ENABLE=0 → SS_HIT=0 after vsync; FRAME still increments.
- W1C of IRQ_STAT issued in the same cycle as a new snapshot that sets pending → pending stays 1. FRAME preset near wrap (run 65536 vsyncs, or force) → 0xFFFF wraps to 0.

Source files
------------

// File: rtl/video_collision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_collision_pkg
// Description : Shared definitions for the sprite collision detector:
//               register offsets (word index = iomem_addr[4:2]), the block
//               select value, CTRL bit positions, the CTRL storage type and
//               a helper that flags sprites overlapping any other sprite.
// Revision    : 1.0 - initial release
// ============================================================================
package video_collision_pkg;

  // Block select value compared against iomem_addr[23:20]
  localparam logic [3:0] VC_BLOCK_SEL = 4'h4;

  // Register word indices (byte offset >> 2)
  localparam logic [2:0] VC_CTRL     = 3'd0;  // 0x00
  localparam logic [2:0] VC_SS_HIT   = 3'd1;  // 0x04
  localparam logic [2:0] VC_BG_HIT   = 3'd2;  // 0x08
  localparam logic [2:0] VC_FRAME    = 3'd3;  // 0x0C
  localparam logic [2:0] VC_IRQ_STAT = 3'd4;  // 0x10

  // CTRL bit positions
  localparam int VC_CTRL_ENABLE_BIT  = 0;
  localparam int VC_CTRL_IRQ_EN_BIT  = 1;
  localparam int VC_CTRL_SS_MASK_LSB = 8;

  typedef struct packed {
    logic [7:0] ss_mask;
    logic       irq_en;
    logic       enable;
  } vc_ctrl_t;

  // Bit i set when sprite i is opaque together with at least one other sprite
  function automatic logic [7:0] vc_ss_hits(input logic [7:0] opq);
    logic [7:0] hits;
    hits = '0;
    for (int i = 0; i < 8; i++) begin
      hits[i] = opq[i] & (|(opq & ~(8'd1 << i)));
    end
    return hits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_collision_if.sv
`default_nettype none
// ============================================================================
// Module      : video_collision_if
// Description : iomem bus bundle between the SoC (master) and the collision
//               detector (slave).
//   iomem_valid  : request, already qualified for the video window
//   iomem_ready  : one-cycle completion pulse
//   iomem_wstrb  : byte write strobes, 0 = read
//   iomem_addr   : byte address
//   iomem_wdata  : write data
//   iomem_rdata  : read data, valid while iomem_ready is high
// Revision    : 1.0 - initial release
// ============================================================================
interface video_collision_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/video_collision_regs.sv
`default_nettype none
// ============================================================================
// Module      : video_collision_regs
// Description : Bus decode, ready pulse generation, CTRL and IRQ_STAT
//               storage and the registered interrupt output.
//   clk, resetn   : clock, asynchronous active-low reset
//   bus           : iomem slave port
//   i_ss_hit      : SS_HIT snapshot for readback
//   i_bg_hit      : BG_HIT snapshot for readback
//   i_frame       : frame counter for readback
//   i_frame_edge  : frame-end strobe (snapshot cycle)
//   i_irq_cond    : collision condition evaluated on the work sets
//   o_ctrl        : CTRL register fields
//   o_irq         : level interrupt (pending & IRQ_EN, registered)
// Revision    : 1.0 - initial release
// ============================================================================
module video_collision_regs
  import video_collision_pkg::*;
#(
  parameter int NUM_SPRITES = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  video_collision_if.slave       bus,
  input  logic [NUM_SPRITES-1:0] i_ss_hit,
  input  logic [NUM_SPRITES-1:0] i_bg_hit,
  input  logic [15:0]            i_frame,
  input  logic                   i_frame_edge,
  input  logic                   i_irq_cond,
  output vc_ctrl_t               o_ctrl,
  output logic                   o_irq
);

  vc_ctrl_t    r_ctrl;
  logic        r_pending;
  logic        r_ready;
  logic        r_hold;
  logic        r_irq;
  logic [31:0] r_rdata;

  logic        w_sel;
  logic [2:0]  w_reg;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_set;
  logic        w_clr;
  logic [31:0] w_rdata;
  logic        w_unused_bus;

  assign w_sel    = (bus.iomem_addr[23:20] == VC_BLOCK_SEL);
  assign w_reg    = bus.iomem_addr[4:2];
  // r_hold blocks a second ready while valid stays high after completion
  assign w_accept = bus.iomem_valid & w_sel & ~r_ready & ~r_hold;
  assign w_wr     = w_accept & (|bus.iomem_wstrb);
  assign w_rd     = w_accept & ~(|bus.iomem_wstrb);
  assign w_set    = i_frame_edge & r_ctrl.irq_en & i_irq_cond;
  assign w_clr    = w_wr & (w_reg == VC_IRQ_STAT) & bus.iomem_wstrb[0]
                    & bus.iomem_wdata[0];

  assign w_unused_bus = ^{bus.iomem_addr[31:24], bus.iomem_addr[19:5],
                          bus.iomem_addr[1:0], bus.iomem_wdata[31:16],
                          bus.iomem_wdata[7:2], bus.iomem_wstrb[3:2]};

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      VC_CTRL: begin
        w_rdata[VC_CTRL_ENABLE_BIT]           = r_ctrl.enable;
        w_rdata[VC_CTRL_IRQ_EN_BIT]           = r_ctrl.irq_en;
        w_rdata[VC_CTRL_SS_MASK_LSB +: 8]     = r_ctrl.ss_mask;
      end
      VC_SS_HIT:   w_rdata[NUM_SPRITES-1:0] = i_ss_hit;
      VC_BG_HIT:   w_rdata[NUM_SPRITES-1:0] = i_bg_hit;
      VC_FRAME:    w_rdata[15:0]            = i_frame;
      VC_IRQ_STAT: w_rdata[0]               = r_pending;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_hold  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      r_hold  <= (r_ready | r_hold) & bus.iomem_valid;
      r_rdata <= w_rd ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl <= '0;
    end else if (w_wr && (w_reg == VC_CTRL)) begin
      if (bus.iomem_wstrb[0]) begin
        r_ctrl.enable <= bus.iomem_wdata[VC_CTRL_ENABLE_BIT];
        r_ctrl.irq_en <= bus.iomem_wdata[VC_CTRL_IRQ_EN_BIT];
      end
      if (bus.iomem_wstrb[1]) begin
        r_ctrl.ss_mask <= bus.iomem_wdata[VC_CTRL_SS_MASK_LSB +: 8];
      end
    end
  end

  // A new frame condition wins over a simultaneous W1C
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_set) begin
        r_pending <= 1'b1;
      end else if (w_clr) begin
        r_pending <= 1'b0;
      end
      r_irq <= r_pending & r_ctrl.irq_en;
    end
  end

  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
  assign o_ctrl          = r_ctrl;
  assign o_irq           = r_irq;

endmodule
`default_nettype wire

// File: rtl/video_collision.sv
`default_nettype none
// ============================================================================
// Module      : video_collision
// Description : Per-frame sprite collision detector. Registers the pixel-path
//               opacity signals, accumulates sprite-vs-sprite and (optionally)
//               sprite-vs-background hits over the visible frame, snapshots
//               them on the vsync assertion edge and raises an interrupt.
//   clk, resetn     : clock, asynchronous active-low reset
//   bus             : iomem slave port (register access)
//   video_active    : current pixel is visible
//   sprite_opaque   : per-sprite opaque bits at this pixel
//   bg_opaque       : background texel is nonzero
//   vga_vsync       : vertical sync (polarity set by VSYNC_ACTIVE_LOW)
//   irq             : level interrupt
// Build option: define VIDEO_COLLISION_BG_EN to include sprite-vs-background
//               detection; otherwise BG_HIT reads 0 and bg_opaque is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module video_collision
  import video_collision_pkg::*;
#(
  parameter int NUM_SPRITES      = 8,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  video_collision_if.slave       bus,
  input  logic                   video_active,
  input  logic [NUM_SPRITES-1:0] sprite_opaque,
  input  logic                   bg_opaque,
  input  logic                   vga_vsync,
  output logic                   irq
);

  vc_ctrl_t               w_ctrl;

  logic                   r_active;
  logic [NUM_SPRITES-1:0] r_opq;
  logic                   r_vsync;
  logic                   r_vsync_d;
  logic                   r_frame_edge;
  logic [NUM_SPRITES-1:0] r_ss_work;
  logic [NUM_SPRITES-1:0] r_ss_hit;
  logic [15:0]            r_frame;

  logic                   w_vs_assert;
  logic                   w_accum;
  logic [7:0]             w_ss_all;
  logic [NUM_SPRITES-1:0] w_ss_pix;
  logic [NUM_SPRITES-1:0] w_bg_work;
  logic [NUM_SPRITES-1:0] w_bg_hit;
  logic                   w_irq_cond;

  // Input stage: every detection decision uses these registered copies
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active     <= 1'b0;
      r_opq        <= '0;
      r_vsync      <= 1'b0;
      r_vsync_d    <= 1'b0;
      r_frame_edge <= 1'b0;
    end else begin
      r_active     <= video_active;
      r_opq        <= sprite_opaque;
      r_vsync      <= vga_vsync;
      r_vsync_d    <= r_vsync;
      r_frame_edge <= w_vs_assert;
    end
  end

  assign w_vs_assert = VSYNC_ACTIVE_LOW ? (r_vsync_d & ~r_vsync)
                                        : (~r_vsync_d & r_vsync);

  assign w_accum  = w_ctrl.enable & r_active;
  assign w_ss_all = vc_ss_hits(8'(r_opq));
  assign w_ss_pix = w_accum ? w_ss_all[NUM_SPRITES-1:0] : '0;

  // On the frame edge the current pixel seeds the freshly cleared work set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ss_work <= '0;
      r_ss_hit  <= '0;
      r_frame   <= '0;
    end else if (r_frame_edge) begin
      r_ss_hit  <= r_ss_work;
      r_ss_work <= w_ss_pix;
      r_frame   <= r_frame + 16'd1;
    end else begin
      r_ss_work <= r_ss_work | w_ss_pix;
    end
  end

`ifdef VIDEO_COLLISION_BG_EN
  logic                   r_bg;
  logic [NUM_SPRITES-1:0] r_bg_work;
  logic [NUM_SPRITES-1:0] r_bg_hit;
  logic [NUM_SPRITES-1:0] w_bg_pix;

  assign w_bg_pix = (w_accum & r_bg) ? r_opq : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bg      <= 1'b0;
      r_bg_work <= '0;
      r_bg_hit  <= '0;
    end else begin
      r_bg <= bg_opaque;
      if (r_frame_edge) begin
        r_bg_hit  <= r_bg_work;
        r_bg_work <= w_bg_pix;
      end else begin
        r_bg_work <= r_bg_work | w_bg_pix;
      end
    end
  end

  assign w_bg_work = r_bg_work;
  assign w_bg_hit  = r_bg_hit;
`else
  logic w_unused_bg;
  assign w_unused_bg = bg_opaque;
  assign w_bg_work   = '0;
  assign w_bg_hit    = '0;
`endif

  // Mask applies only to sprite-vs-sprite; any background hit qualifies
  assign w_irq_cond = (|(8'(r_ss_work) & w_ctrl.ss_mask)) | (|w_bg_work);

  video_collision_regs #(
    .NUM_SPRITES (NUM_SPRITES)
  ) u_regs (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .i_ss_hit     (r_ss_hit),
    .i_bg_hit     (w_bg_hit),
    .i_frame      (r_frame),
    .i_frame_edge (r_frame_edge),
    .i_irq_cond   (w_irq_cond),
    .o_ctrl       (w_ctrl),
    .o_irq        (irq)
  );

endmodule
`default_nettype wire

// File: tb/tb_video_collision.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_collision
// Description : Self-checking bench for video_collision with a frame-level
//               reference model (set arithmetic on sprite masks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_collision;
  localparam int NS = 8;
`ifdef VIDEO_COLLISION_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif
  localparam logic [31:0] BASE    = 32'h0540_0000;
  localparam logic [7:0]  O_CTRL  = 8'h00;
  localparam logic [7:0]  O_SS    = 8'h04;
  localparam logic [7:0]  O_BG    = 8'h08;
  localparam logic [7:0]  O_FRAME = 8'h0C;
  localparam logic [7:0]  O_IRQ   = 8'h10;

  logic          clk;
  logic          resetn;
  logic          video_active;
  logic [NS-1:0] sprite_opaque;
  logic          bg_opaque;
  logic          vga_vsync;
  logic          irq;

  video_collision_if bus_if ();

  video_collision #(.NUM_SPRITES(NS), .VSYNC_ACTIVE_LOW(1'b1)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus_if),
    .video_active  (video_active),
    .sprite_opaque (sprite_opaque),
    .bg_opaque     (bg_opaque),
    .vga_vsync     (vga_vsync),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model state
  logic [NS-1:0] m_ss_work, m_bg_work, m_ss_hit, m_bg_hit;
  logic [15:0]   m_frame;
  logic          m_pending, m_enable, m_irq_en;
  logic [7:0]    m_mask;

  task automatic model_reset();
    m_ss_work = '0; m_bg_work = '0; m_ss_hit = '0; m_bg_hit = '0;
    m_frame = '0; m_pending = 1'b0; m_enable = 1'b0; m_irq_en = 1'b0;
    m_mask = '0;
  endtask

  task automatic model_frame();
    if (m_irq_en && (((8'(m_ss_work) & m_mask) != 8'h00) || (m_bg_work != '0)))
      m_pending = 1'b1;
    m_ss_hit  = m_ss_work;
    m_bg_hit  = m_bg_work;
    m_ss_work = '0;
    m_bg_work = '0;
    m_frame   = m_frame + 16'd1;
  endtask

  // ---------------- bus helpers ----------------
  task automatic bus_access(input logic [7:0] off, input logic [3:0] strb,
                            input logic [31:0] wd, output logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    rd = '0;
    @(negedge clk);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = BASE | 32'(off);
    bus_if.iomem_wstrb = strb;
    bus_if.iomem_wdata = wd;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus_if.iomem_ready) begin
        ok = 1'b1;
        rd = bus_if.iomem_rdata;
        break;
      end
    end
    @(negedge clk);
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bus_timeout off=%h: ready=0 required=1", off);
    end
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] rd);
    bus_access(off, 4'h0, 32'h0, rd);
  endtask

  task automatic write_ctrl(input bit en, input bit ie, input logic [7:0] mask);
    logic [31:0] d;
    bus_access(O_CTRL, 4'hF, {16'h0, mask, 6'h0, ie, en}, d);
    m_enable = en; m_irq_en = ie; m_mask = mask;
    @(negedge clk);
  endtask

  task automatic w1c_irq();
    logic [31:0] d;
    bus_access(O_IRQ, 4'h1, 32'h1, d);
    m_pending = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- video helpers ----------------
  task automatic pixel(input bit act, input logic [NS-1:0] opq, input bit bg);
    @(negedge clk);
    video_active = act; sprite_opaque = opq; bg_opaque = bg;
    @(negedge clk);
    video_active = 1'b0; sprite_opaque = '0; bg_opaque = 1'b0;
    if (m_enable && act) begin
      for (int i = 0; i < NS; i++) begin
        if (opq[i] && ($countones(opq) > 1)) m_ss_work[i] = 1'b1;
        if (opq[i] && bg && BG_EN) m_bg_work[i] = 1'b1;
      end
    end
  endtask

  task automatic frame();
    @(negedge clk);
    vga_vsync = 1'b0;
    repeat (3) @(negedge clk);
    vga_vsync = 1'b1;
    repeat (4) @(negedge clk);
    model_frame();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  offs [5];
    offs = '{O_CTRL, O_SS, O_BG, O_FRAME, O_IRQ};
    checks++;
    if (irq !== 1'b0 || bus_if.iomem_ready !== 1'b0 || bus_if.iomem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b ready=%b rdata=%h required 0/0/0",
               irq, bus_if.iomem_ready, bus_if.iomem_rdata);
    end
    for (int k = 0; k < 5; k++) begin
      bus_read(offs[k], d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg off=%h: got %h required 0", offs[k], d);
      end
    end
  endtask

  task automatic test_ss_pair();
    logic [31:0] d;
    write_ctrl(1'b1, 1'b0, 8'hFF);
    bus_read(O_CTRL, d);
    checks++;
    if (d !== 32'h0000_FF01) begin
      errors++; $display("FAIL ctrl_readback: got %h required 0000ff01", d);
    end
    pixel(1'b1, 8'h09, 1'b0);
    frame();
    bus_read(O_SS, d);
    checks++;
    if (d !== 32'(m_ss_hit) || d !== 32'h09) begin
      errors++; $display("FAIL ss_pair: got %h required %h", d, 32'(m_ss_hit));
    end
    bus_read(O_BG, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL ss_pair_bg: got %h required 0", d);
    end
    bus_read(O_FRAME, d);
    checks++;
    if (d !== 32'(m_frame)) begin
      errors++; $display("FAIL ss_pair_frame: got %h required %h", d, 32'(m_frame));
    end
  endtask

  task automatic test_bg_irq();
    logic [31:0] d;
    write_ctrl(1'b1, 1'b1, 8'h00);
    pixel(1'b1, 8'h04, 1'b1);
    frame();
    bus_read(O_BG, d);
    checks++;
    if (d !== (BG_EN ? 32'h4 : 32'h0)) begin
      errors++; $display("FAIL bg_hit: got %h required %h", d, BG_EN ? 32'h4 : 32'h0);
    end
    checks++;
    if (irq !== BG_EN) begin
      errors++; $display("FAIL bg_irq: got %b required %b", irq, BG_EN);
    end
    w1c_irq();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL w1c_irq: got %b required 0", irq);
    end
    bus_read(O_IRQ, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL w1c_stat: got %h required 0", d);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    write_ctrl(1'b1, 1'b1, 8'h01);
    pixel(1'b1, 8'h06, 1'b0);
    frame();
    bus_read(O_SS, d);
    checks++;
    if (d !== 32'h06) begin
      errors++; $display("FAIL mask_ss: got %h required 06", d);
    end
    checks++;
    if (irq !== 1'b0 || m_pending !== 1'b0) begin
      errors++; $display("FAIL mask_noirq: got %b required 0", irq);
    end
    pixel(1'b1, 8'h03, 1'b0);
    frame();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL mask_irq: got %b required 1", irq);
    end
    w1c_irq();
  endtask

  task automatic test_gating();
    logic [31:0] d;
    write_ctrl(1'b1, 1'b0, 8'hFF);
    pixel(1'b0, 8'h03, 1'b1);
    write_ctrl(1'b0, 1'b0, 8'hFF);
    pixel(1'b1, 8'h03, 1'b1);
    frame();
    bus_read(O_SS, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL gating_ss: got %h required 0", d);
    end
    bus_read(O_FRAME, d);
    checks++;
    if (d !== 32'(m_frame)) begin
      errors++; $display("FAIL gating_frame: got %h required %h", d, 32'(m_frame));
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus_if.iomem_valid = 1'b1; bus_if.iomem_addr = BASE | 32'(O_FRAME);
    bus_if.iomem_wstrb = 4'h0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (bus_if.iomem_ready) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL held_valid_pulses: got %0d required 1", pulses);
    end
    @(negedge clk); bus_if.iomem_valid = 1'b0;
    @(negedge clk); bus_if.iomem_valid = 1'b1;
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (bus_if.iomem_ready) pulses++;
    end
    @(negedge clk); bus_if.iomem_valid = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL revalid_pulses: got %0d required 1", pulses);
    end
    // Other block in the window and an unmapped offset
    pulses = 0;
    @(negedge clk);
    bus_if.iomem_valid = 1'b1; bus_if.iomem_addr = 32'h0530_0000;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (bus_if.iomem_ready) pulses++;
    end
    @(negedge clk); bus_if.iomem_valid = 1'b0;
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL unselected_ready: got %0d required 0", pulses);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_read(8'h14, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: got %h required 0", d);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    bit rdy;
    write_ctrl(1'b1, 1'b1, 8'hFF);
    pixel(1'b1, 8'h03, 1'b0);
    frame();
    pixel(1'b1, 8'h30, 1'b0);
    // Vsync falls; the W1C lands on the snapshot edge two cycles later
    @(negedge clk); vga_vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_if.iomem_valid = 1'b1; bus_if.iomem_addr = BASE | 32'(O_IRQ);
    bus_if.iomem_wstrb = 4'h1; bus_if.iomem_wdata = 32'h1;
    @(posedge clk); #1;
    rdy = bus_if.iomem_ready;
    @(negedge clk);
    bus_if.iomem_valid = 1'b0; bus_if.iomem_wstrb = 4'h0;
    vga_vsync = 1'b1;
    repeat (4) @(negedge clk);
    m_pending = 1'b0;
    model_frame();
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL race_ready: got %b required 1", rdy);
    end
    bus_read(O_IRQ, d);
    checks++;
    if (d !== 32'(m_pending)) begin
      errors++; $display("FAIL race_pending: got %h required %h", d, 32'(m_pending));
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL race_irq: got %b required 1", irq);
    end
    w1c_irq();
  endtask

  task automatic test_frame_wrap();
    logic [31:0] d;
    @(negedge clk);
    force dut.r_frame = 16'hFFFE;
    @(negedge clk);
    release dut.r_frame;
    m_frame = 16'hFFFE;
    frame();
    bus_read(O_FRAME, d);
    checks++;
    if (d !== 32'h0000_FFFF) begin
      errors++; $display("FAIL frame_ffff: got %h required 0000ffff", d);
    end
    frame();
    bus_read(O_FRAME, d);
    checks++;
    if (d !== 32'(m_frame) || d !== 32'h0) begin
      errors++; $display("FAIL frame_wrap: got %h required 0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int f = 0; f < 6; f++) begin
      write_ctrl(($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
      for (int p = 0; p < 8; p++) begin
        pixel(($urandom_range(0, 3) != 0), NS'($urandom & $urandom), 1'($urandom));
      end
      frame();
      bus_read(O_SS, d);
      checks++;
      if (d !== 32'(m_ss_hit)) begin
        errors++; $display("FAIL rand_ss f=%0d: got %h required %h", f, d, 32'(m_ss_hit));
      end
      bus_read(O_BG, d);
      checks++;
      if (d !== 32'(m_bg_hit)) begin
        errors++; $display("FAIL rand_bg f=%0d: got %h required %h", f, d, 32'(m_bg_hit));
      end
      bus_read(O_FRAME, d);
      checks++;
      if (d !== 32'(m_frame)) begin
        errors++; $display("FAIL rand_frame f=%0d: got %h required %h", f, d, 32'(m_frame));
      end
      checks++;
      if (irq !== (m_pending & m_irq_en)) begin
        errors++; $display("FAIL rand_irq f=%0d: got %b required %b", f, irq, m_pending & m_irq_en);
      end
      w1c_irq();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [7:0]  offs [5];
    offs = '{O_CTRL, O_SS, O_BG, O_FRAME, O_IRQ};
    write_ctrl(1'b1, 1'b1, 8'hFF);
    pixel(1'b1, 8'h11, 1'b1);
    frame();
    pixel(1'b1, 8'h22, 1'b1);
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    model_reset();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL midreset_irq: got %b required 0", irq);
    end
    for (int k = 0; k < 5; k++) begin
      bus_read(offs[k], d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL midreset_reg off=%h: got %h required 0", offs[k], d);
      end
    end
    write_ctrl(1'b1, 1'b0, 8'hFF);
    frame();
    bus_read(O_FRAME, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL midreset_frame: got %h required 1", d);
    end
    bus_read(O_SS, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL midreset_ss: got %h required 0", d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    video_active = 1'b0; sprite_opaque = '0; bg_opaque = 1'b0; vga_vsync = 1'b1;
    bus_if.iomem_valid = 1'b0; bus_if.iomem_wstrb = '0;
    bus_if.iomem_addr = '0; bus_if.iomem_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_ss_pair();
    test_bg_irq();
    test_mask();
    test_gating();
    test_back_to_back();
    test_unmapped();
    test_w1c_race();
    test_frame_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
